mole_game_fsm: RTL and testbench

//  Round/game controller for the whack-a-mole design. Sits upstream of the mole detector and score updater:

---
 rtl/mole_game_pkg.sv | 12 +
 rtl/mole_game_fsm_if.sv | 18 +
 rtl/ms_countdown.sv | 16 +
 rtl/mole_game_fsm.sv | 100 ++++++++++
 tb/tb_mole_game_fsm.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mole_game_pkg.sv
// mole_game_pkg: state encoding, timing constants and lit-time helper for the mole game controller
package mole_game_pkg;
  typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, DONE} state_t;
  localparam int MS_PER_S = 1000;
  localparam int MAX_RETRY = 8;
  localparam int LEVEL_MAX = 15;
  function automatic logic [15:0] up_ms_f(input logic [3:0] lvl, input int start_ms, input int min_ms, input int step_ms);
    int t;
    t = start_ms - int'(lvl) * step_ms;
    return 16'(t < min_ms ? min_ms : t);
  endfunction
endpackage

// File: rtl/mole_game_fsm_if.sv
// mole_game_fsm_if: control/status bundle between the mole game controller and its environment
interface mole_game_fsm_if #(parameter int N_MOLES = 10);
  logic start, tick_ms;
  logic [4:0] rand_idx;
  logic [N_MOLES-1:0] btn_edge, mole_onehot;
  logic hit_pulse, miss_pulse;
  logic [3:0] level;
  logic [7:0] time_left_s;
  logic game_active, game_over;
  modport master (
    output start, tick_ms, rand_idx, btn_edge,
    input mole_onehot, hit_pulse, miss_pulse, level, time_left_s, game_active, game_over
  );
  modport slave (
    input start, tick_ms, rand_idx, btn_edge,
    output mole_onehot, hit_pulse, miss_pulse, level, time_left_s, game_active, game_over
  );
endinterface

// File: rtl/ms_countdown.sv
// ms_countdown: loadable millisecond down-counter; zero flags the tick that takes it from 1 to 0
module ms_countdown (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        tick,
  output logic        zero
);
  logic [15:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (tick && cnt != '0) cnt <= cnt - 16'd1;
  assign zero = tick && cnt == 16'd1;
endmodule

// File: rtl/mole_game_fsm.sv
// mole_game_fsm: whack-a-mole round/game controller (spawn, light, judge, game countdown).
// Define MOLE_GAME_PENALTY_EN to score a wrong button press on a lit mole as a miss.
module mole_game_fsm #(
  parameter int N_MOLES        = 10,
  parameter int GAME_SECONDS   = 30,
  parameter int UP_MS_START    = 1000,
  parameter int UP_MS_MIN      = 300,
  parameter int UP_MS_STEP     = 100,
  parameter int HITS_PER_LEVEL = 5,
  parameter int GAP_MS         = 200
) (
  input logic clk,
  input logic rst,
  mole_game_fsm_if.slave bus
);
  import mole_game_pkg::*;
  localparam logic [N_MOLES-1:0] ONE = {{(N_MOLES-1){1'b0}}, 1'b1};
  state_t state;
  logic [4:0] prev_idx, pick;
  logic [3:0] retry;
  logic [7:0] hit_cnt;
  logic [9:0] ms_cnt;
  logic [15:0] up_ms;
  logic sample_ok, take, game_end, hit, penalty, up_zero, gap_zero, leave_up, level_up;
  assign sample_ok = {1'b0, bus.rand_idx} < 6'(N_MOLES) && bus.rand_idx != prev_idx;
  assign take = sample_ok || retry == 4'(MAX_RETRY);
  assign pick = sample_ok ? bus.rand_idx : prev_idx == 5'(N_MOLES - 1) ? 5'd0 : prev_idx + 5'd1;
  // Only the lit mole's bit can match, so this is the correct-button test
  assign hit = |(bus.btn_edge & bus.mole_onehot);
`ifdef MOLE_GAME_PENALTY_EN
  assign penalty = |bus.btn_edge && !hit;
`else
  assign penalty = 1'b0;
`endif
  assign leave_up = hit || up_zero || penalty;
  assign level_up = hit && hit_cnt == 8'(HITS_PER_LEVEL - 1);
  assign game_end = bus.game_active && bus.tick_ms && ms_cnt == 10'(MS_PER_S - 1) && bus.time_left_s == 8'd1;
  assign up_ms = up_ms_f(bus.level, UP_MS_START, UP_MS_MIN, UP_MS_STEP);
  assign bus.game_active = state inside {SPAWN, UP, GAP};
  assign bus.game_over = state == DONE;
  ms_countdown up_timer (
    .clk(clk), .rst(rst), .load(state == SPAWN && take && !game_end), .value(up_ms),
    .tick(bus.tick_ms && state == UP), .zero(up_zero)
  );
  ms_countdown gap_timer (
    .clk(clk), .rst(rst), .load(state == UP && leave_up && !game_end), .value(16'(GAP_MS)),
    .tick(bus.tick_ms && state == GAP), .zero(gap_zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.mole_onehot <= '0;
      bus.hit_pulse <= 1'b0;
      bus.miss_pulse <= 1'b0;
      bus.level <= '0;
      bus.time_left_s <= 8'(GAME_SECONDS);
      ms_cnt <= '0;
      prev_idx <= 5'(N_MOLES - 1);
      retry <= '0;
      hit_cnt <= '0;
    end else begin
      bus.hit_pulse <= 1'b0;
      bus.miss_pulse <= 1'b0;
      if (bus.game_active && bus.tick_ms) begin
        ms_cnt <= ms_cnt == 10'(MS_PER_S - 1) ? 10'd0 : ms_cnt + 10'd1;
        if (ms_cnt == 10'(MS_PER_S - 1)) bus.time_left_s <= bus.time_left_s - 8'd1;
      end
      // Game end overrides any verdict on the current mole
      if (game_end) begin
        state <= DONE;
        bus.mole_onehot <= '0;
      end else
        case (state)
          IDLE, DONE: if (bus.start) begin
            state <= SPAWN;
            bus.level <= '0;
            bus.time_left_s <= 8'(GAME_SECONDS);
            ms_cnt <= '0;
            hit_cnt <= '0;
            retry <= '0;
          end
          SPAWN: if (take) begin
            state <= UP;
            bus.mole_onehot <= ONE << pick;
            prev_idx <= pick;
            retry <= '0;
          end else retry <= retry + 4'd1;
          UP: if (leave_up) begin
            state <= GAP;
            bus.mole_onehot <= '0;
            bus.hit_pulse <= hit;
            bus.miss_pulse <= !hit;
            hit_cnt <= !hit ? hit_cnt : level_up ? 8'd0 : hit_cnt + 8'd1;
            if (level_up && bus.level != 4'(LEVEL_MAX)) bus.level <= bus.level + 4'd1;
          end
          GAP: if (gap_zero) state <= SPAWN;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_mole_game_fsm.sv
// tb_mole_game_fsm: directed scenarios plus a randomized run against a behavioural game model
module tb_mole_game_fsm;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0, ticks = 0;
`ifdef MOLE_GAME_PENALTY_EN
  localparam bit PEN = 1;
`else
  localparam bit PEN = 0;
`endif
  mole_game_fsm_if #(.N_MOLES(10)) bus ();
  mole_game_fsm dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1 choosing, 2 lit, 3 dark, 4 over
  int m_phase, m_mole, m_prev, m_tries, m_left, m_level, m_hits, m_secs, m_ms;
  bit m_hit, m_miss;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_ms = 1;
      cyc();
      ticks++;
    end
    bus.tick_ms = 0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_mole = -1; m_prev = 9; m_tries = 0; m_left = 0;
    m_level = 0; m_hits = 0; m_secs = 30; m_ms = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic model_light(input int idx);
    m_mole = idx; m_prev = idx; m_tries = 0; m_phase = 2;
    m_left = 1000 - 100 * m_level < 300 ? 300 : 1000 - 100 * m_level;
  endtask

  task automatic model_step(input bit st, input bit tk, input int ri, input logic [9:0] be);
    bit active, ends, got, wrong;
    active = m_phase >= 1 && m_phase <= 3;
    ends = active && tk && m_ms == 999 && m_secs == 1;
    m_hit = 0; m_miss = 0;
    if (active && tk) begin
      if (m_ms == 999) begin m_ms = 0; m_secs--; end else m_ms++;
    end
    if (ends) begin
      m_phase = 4; m_mole = -1;
    end else if (m_phase == 0 || m_phase == 4) begin
      if (st) begin m_phase = 1; m_level = 0; m_secs = 30; m_ms = 0; m_hits = 0; m_tries = 0; end
    end else if (m_phase == 1) begin
      if (ri < 10 && ri != m_prev) model_light(ri);
      else if (m_tries == 8) model_light((m_prev + 1) % 10);
      else m_tries++;
    end else if (m_phase == 2) begin
      got = be[m_mole];
      wrong = be != 0 && !got;
      if (got || (tk && m_left == 1) || (PEN && wrong)) begin
        m_hit = got; m_miss = !got; m_mole = -1; m_left = 200; m_phase = 3;
        if (got && ++m_hits == 5) begin
          m_hits = 0;
          if (m_level < 15) m_level++;
        end
      end else if (tk) m_left--;
    end else if (tk) begin
      m_left--;
      if (m_left == 0) m_phase = 1;
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.tick_ms = 0; bus.rand_idx = 0; bus.btn_edge = 0;
    rst = 1; cyc(); cyc(); rst = 0; cyc();
    checks++; if (bus.mole_onehot !== 10'h0) begin errors++; $display("FAIL reset_mole got %h exp 000", bus.mole_onehot); end
    checks++; if (bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", bus.hit_pulse, bus.miss_pulse); end
    checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.level); end
    checks++; if (bus.time_left_s !== 8'd30) begin errors++; $display("FAIL reset_time got %0d exp 30", bus.time_left_s); end
    checks++; if (bus.game_active !== 1'b0 || bus.game_over !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", bus.game_active, bus.game_over); end
  endtask

  task automatic test_first_mole();
    bus.rand_idx = 3; bus.start = 1; cyc(); bus.start = 0; cyc();
    checks++; if (bus.mole_onehot !== 10'h008) begin errors++; $display("FAIL first_mole got %h exp 008", bus.mole_onehot); end
    checks++; if (bus.level !== 4'd0 || bus.time_left_s !== 8'd30) begin errors++; $display("FAIL first_status got lvl %0d time %0d exp 0 30", bus.level, bus.time_left_s); end
    checks++; if (bus.game_active !== 1'b1) begin errors++; $display("FAIL first_active got %b exp 1", bus.game_active); end
  endtask

  task automatic test_hit();
    bus.btn_edge = 10'h008; cyc(); bus.btn_edge = 0;
    checks++; if (bus.hit_pulse !== 1'b1 || bus.miss_pulse !== 1'b0) begin errors++; $display("FAIL hit_pulse got %b%b exp 10", bus.hit_pulse, bus.miss_pulse); end
    checks++; if (bus.mole_onehot !== 10'h0) begin errors++; $display("FAIL hit_mole_off got %h exp 000", bus.mole_onehot); end
    bus.rand_idx = 5; tick_n(199);
    checks++; if (bus.mole_onehot !== 10'h0 || bus.hit_pulse !== 1'b0) begin errors++; $display("FAIL gap_dark got %h %b exp 000 0", bus.mole_onehot, bus.hit_pulse); end
    tick_n(1); cyc();
    checks++; if (bus.mole_onehot !== 10'h020) begin errors++; $display("FAIL gap_respawn got %h exp 020", bus.mole_onehot); end
  endtask

  task automatic test_miss();
    int misses = 0, first = 0;
    for (int i = 1; i <= 1000; i++) begin
      bus.tick_ms = 1; cyc(); ticks++;
      if (bus.miss_pulse === 1'b1) begin misses++; if (first == 0) first = i; end
    end
    bus.tick_ms = 0;
    checks++; if (first !== 1000) begin errors++; $display("FAIL miss_latency got %0d exp 1000", first); end
    checks++; if (bus.mole_onehot !== 10'h0 || bus.game_active !== 1'b1) begin errors++; $display("FAIL miss_gap got %h %b exp 000 1", bus.mole_onehot, bus.game_active); end
    for (int i = 0; i < 3; i++) begin cyc(); if (bus.miss_pulse === 1'b1) misses++; end
    checks++; if (misses !== 1) begin errors++; $display("FAIL miss_count got %0d exp 1", misses); end
  endtask

  task automatic test_level();
    int list[4] = '{1, 2, 1, 2};
    int n = 0;
    logic [9:0] exp_m;
    foreach (list[k]) begin
      exp_m = 10'd1 << list[k];
      bus.rand_idx = 5'(list[k]); tick_n(200); cyc();
      checks++; if (bus.mole_onehot !== exp_m) begin errors++; $display("FAIL level_mole got %h exp %h", bus.mole_onehot, exp_m); end
      bus.btn_edge = exp_m; cyc(); bus.btn_edge = 0;
      checks++; if (bus.hit_pulse !== 1'b1) begin errors++; $display("FAIL level_hit got %b exp 1", bus.hit_pulse); end
    end
    checks++; if (bus.level !== 4'd1) begin errors++; $display("FAIL level_up got %0d exp 1", bus.level); end
    bus.rand_idx = 7; tick_n(200); cyc();
    while (n < 2000 && bus.miss_pulse !== 1'b1) begin tick_n(1); n++; end
    checks++; if (n !== 900) begin errors++; $display("FAIL level_up_time got %0d exp 900", n); end
  endtask

  task automatic test_retry();
    bus.rand_idx = 3; tick_n(200); cyc();
    checks++; if (bus.mole_onehot !== 10'h008) begin errors++; $display("FAIL retry_setup got %h exp 008", bus.mole_onehot); end
    bus.btn_edge = 10'h008; cyc(); bus.btn_edge = 0;
    tick_n(199); bus.rand_idx = 12; tick_n(1);
    for (int i = 0; i < 10; i++) begin
      bus.rand_idx = i < 4 ? 5'd12 : 5'd3;
      cyc();
      if (i == 7) begin checks++; if (bus.mole_onehot !== 10'h0) begin errors++; $display("FAIL retry_early got %h exp 000", bus.mole_onehot); end end
    end
    checks++; if (bus.mole_onehot !== 10'h010) begin errors++; $display("FAIL retry_fallback got %h exp 010", bus.mole_onehot); end
  endtask

  task automatic test_penalty();
    logic [9:0] exp_m;
    exp_m = PEN ? 10'h0 : 10'h010;
    bus.btn_edge = 10'h001; cyc(); bus.btn_edge = 0;
    checks++; if (bus.miss_pulse !== PEN || bus.hit_pulse !== 1'b0) begin errors++; $display("FAIL wrong_btn_pulse got %b%b exp 0%b", bus.hit_pulse, bus.miss_pulse, PEN); end
    checks++; if (bus.mole_onehot !== exp_m) begin errors++; $display("FAIL wrong_btn_mole got %h exp %h", bus.mole_onehot, exp_m); end
  endtask

  task automatic test_game_over();
    int n = 0;
    while (bus.game_over !== 1'b1 && ticks < 30100) begin
      bus.btn_edge = ticks == 29999 ? '1 : '0;
      tick_n(1);
    end
    bus.btn_edge = 0;
    checks++; if (ticks !== 30000) begin errors++; $display("FAIL over_ticks got %0d exp 30000", ticks); end
    checks++; if (bus.game_over !== 1'b1 || bus.game_active !== 1'b0) begin errors++; $display("FAIL over_flags got %b%b exp 01", bus.game_active, bus.game_over); end
    checks++; if (bus.time_left_s !== 8'd0 || bus.mole_onehot !== 10'h0) begin errors++; $display("FAIL over_state got %0d %h exp 0 000", bus.time_left_s, bus.mole_onehot); end
    checks++; if (bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin errors++; $display("FAIL over_pulses got %b%b exp 00", bus.hit_pulse, bus.miss_pulse); end
    bus.start = 1; cyc(); bus.start = 0;
    checks++; if (bus.game_active !== 1'b1 || bus.game_over !== 1'b0) begin errors++; $display("FAIL restart_flags got %b%b exp 10", bus.game_active, bus.game_over); end
    checks++; if (bus.level !== 4'd0 || bus.time_left_s !== 8'd30) begin errors++; $display("FAIL restart_status got %0d %0d exp 0 30", bus.level, bus.time_left_s); end
    tick_n(1000);
    while (n < 2000 && bus.mole_onehot === 10'h0) begin bus.rand_idx = 5'($urandom_range(9)); tick_n(1); n++; end
    checks++; if (bus.mole_onehot === 10'h0) begin errors++; $display("FAIL rst_setup got %h exp nonzero", bus.mole_onehot); end
    #3 rst = 1;
    #1;
    checks++; if (bus.mole_onehot !== 10'h0 || bus.game_active !== 1'b0) begin errors++; $display("FAIL async_rst got %h %b exp 000 0", bus.mole_onehot, bus.game_active); end
    checks++; if (bus.time_left_s !== 8'd30 || bus.level !== 4'd0) begin errors++; $display("FAIL async_rst_status got %0d %0d exp 30 0", bus.time_left_s, bus.level); end
    checks++; if (bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin errors++; $display("FAIL async_rst_pulses got %b%b exp 00", bus.hit_pulse, bus.miss_pulse); end
    cyc(); rst = 0;
  endtask

  task automatic test_random();
    logic [9:0] be, exp_m;
    bit st, tk;
    int ri, r;
    bus.start = 0; bus.tick_ms = 0; bus.btn_edge = 0;
    rst = 1; cyc(); rst = 0; model_reset();
    for (int i = 0; i < 36000 && errors < 50; i++) begin
      st = $urandom_range(63) == 0;
      tk = $urandom_range(15) != 0;
      ri = $urandom_range(15);
      r = $urandom_range(31);
      be = '0;
      if (r == 0 && (i / 3000) % 2 == 1 && m_mole >= 0) be = 10'd1 << m_mole;
      else if (r == 1) be = 10'd1 << $urandom_range(9);
      else if (r == 2) be = 10'($urandom);
      bus.start = st; bus.tick_ms = tk; bus.rand_idx = 5'(ri); bus.btn_edge = be;
      model_step(st, tk, ri, be);
      cyc();
      exp_m = m_mole < 0 ? 10'h0 : 10'd1 << m_mole;
      checks++; if (bus.mole_onehot !== exp_m) begin errors++; $display("FAIL rnd_mole cyc %0d got %h exp %h", i, bus.mole_onehot, exp_m); end
      checks++; if (bus.hit_pulse !== m_hit) begin errors++; $display("FAIL rnd_hit cyc %0d got %b exp %b", i, bus.hit_pulse, m_hit); end
      checks++; if (bus.miss_pulse !== m_miss) begin errors++; $display("FAIL rnd_miss cyc %0d got %b exp %b", i, bus.miss_pulse, m_miss); end
      checks++; if (bus.level !== 4'(m_level)) begin errors++; $display("FAIL rnd_level cyc %0d got %0d exp %0d", i, bus.level, m_level); end
      checks++; if (bus.time_left_s !== 8'(m_secs)) begin errors++; $display("FAIL rnd_time cyc %0d got %0d exp %0d", i, bus.time_left_s, m_secs); end
      checks++; if (bus.game_active !== (m_phase >= 1 && m_phase <= 3)) begin errors++; $display("FAIL rnd_active cyc %0d got %b exp phase %0d", i, bus.game_active, m_phase); end
      checks++; if (bus.game_over !== (m_phase == 4)) begin errors++; $display("FAIL rnd_over cyc %0d got %b exp phase %0d", i, bus.game_over, m_phase); end
    end
  endtask

  initial begin
    test_reset();
    test_first_mole();
    test_hit();
    test_miss();
    test_level();
    test_retry();
    test_penalty();
    test_game_over();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule
